divider_datapath: RTL and testbench
===================================

DIVIDER_DATAPATH -- requirements
Module: divider_datapath

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 dividend_in  input  32  unsigned dividend, sampled on w_ctrl_reg1.
REQ-005 divisor_in  input  32  unsigned divisor, sampled on w_ctrl_reg2.
REQ-006 w_ctrl_reg1  input  1  load dividend and start a new operation.
REQ-007 w_ctrl_reg2  input  1  load divisor.
REQ-008 SLL_ctrl  input  1  perform one shift/trial-subtract iteration.
REQ-009 SRL_ctrl  input  1  commit request.
REQ-010 rdy  input  1  controller ready; qualifies SRL_ctrl.
REQ-011 quotient  output  32  registered quotient of the last commit.
REQ-012 remainder  output  32  registered remainder of the last commit.
REQ-013 result_valid  output  1  one-cycle pulse in the cycle after a commit.
REQ-014 seq_err  output  1  sticky flag: a commit occurred with an iteration count other than 32.

Function
REQ-015 Internal state SHALL be: rem (64 bit), dvsr (32 bit), and iter_cnt (6 bit, saturating at 63).
REQ-016 Only one operation SHALL execute per clock, with priority w_ctrl_reg1 > w_ctrl_reg2 > commit (SRL_ctrl && rdy) > SLL_ctrl; lower-priority controls in the same cycle SHALL be ignored.
REQ-017 On w_ctrl_reg1: rem SHALL load {32'h0, dividend_in}, iter_cnt SHALL clear to 0, and seq_err SHALL clear.
REQ-018 On w_ctrl_reg2: dvsr SHALL load divisor_in; rem and iter_cnt SHALL be unchanged.
REQ-019 On SLL_ctrl, the iteration SHALL proceed as follows.
  - Compute t = rem<<1.
  - Compute d = {1'b0, t[63:32]} - {1'b0, dvsr} (33 bit).
  - If d[32]==0, rem SHALL become {d[31:0], t[31:1], 1'b1}; otherwise rem SHALL become t.
  - iter_cnt SHALL increment by 1.
REQ-020 After exactly 32 iterations, rem[31:0] SHALL hold the quotient and rem[63:32] SHALL hold the remainder.
REQ-021 On commit, quotient SHALL take rem[31:0] and remainder SHALL take rem[63:32].
REQ-022 result_valid SHALL go high in the following cycle for exactly one cycle, with latency 1 clock from the commit edge.
REQ-023 A commit with iter_cnt != 32 SHALL still load the outputs and SHALL set seq_err.
REQ-024 SRL_ctrl with rdy=0 SHALL be a no-op.
REQ-025 Back-to-back commits SHALL each pulse result_valid; a held SRL_ctrl&&rdy SHALL keep result_valid high.
REQ-026 SLL_ctrl beyond 63 iterations SHALL saturate iter_cnt but SHALL still shift rem.
REQ-027 The outputs SHALL hold the last committed values until the next commit or reset.

Reset
REQ-028 On rst, rem, dvsr, iter_cnt, quotient and remainder SHALL be 0, and result_valid, seq_err and div_zero SHALL be 0, immediately and independent of clk.
REQ-029 A reset asserted mid-operation SHALL abandon the operation; no result_valid SHALL follow reset release.

Configuration
REQ-030 The macro DIV_ZERO_DETECT_EN SHALL control divide-by-zero detection.
  - When defined, an output div_zero (1 bit, registered) SHALL load (dvsr==0) at each commit.
  - When defined, div_zero SHALL be cleared by w_ctrl_reg1.
  - When not defined, the port and its logic SHALL be absent.
  - Quotient and remainder behaviour SHALL be identical in both builds (divisor 0 yields quotient 32'hFFFFFFFF, remainder = dividend).

Structure
REQ-031 A shared package SHALL hold the following constants: DATA_W=32, REM_W=64, ITER_N=32, CNT_W=6.
REQ-032 One sub-module, div_trial_sub, SHALL implement the combinational 33-bit trial subtract and return the new rem value.

Verification
REQ-033 The bench SHALL cover the following directed scenarios.
  - dividend 100, divisor 7, 32 SLL, commit -> quotient 14, remainder 2, result_valid 1 cycle, seq_err 0.
  - dividend 32'hFFFFFFFF, divisor 1 -> quotient 32'hFFFFFFFF, remainder 0.
  - dividend 5, divisor 10 -> quotient 0, remainder 5.
  - divisor 0, dividend 32'h1234 -> quotient 32'hFFFFFFFF, remainder 32'h1234; div_zero=1 with DIV_ZERO_DETECT_EN.
  - commit after 10 SLL -> seq_err=1; then w_ctrl_reg1 -> seq_err=0.
  - rst mid-iteration and simultaneous w_ctrl_reg1+SLL_ctrl -> all outputs 0 / load wins, iter_cnt=0.

Source files
------------

// File: rtl/divider_datapath_pkg.sv
// Shared widths, operation encoding and control decode for the restoring divider datapath.
package divider_datapath_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REM_W  = 64;
    localparam int unsigned ITER_N = 32;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [2:0] {
        OpIdle,
        OpLoadDividend,
        OpLoadDivisor,
        OpCommit,
        OpShift
    } op_e;

    // One operation per clock; the highest-priority control wins, the rest are dropped.
    function automatic op_e decode_op(input logic load_dvd, input logic load_dvsr,
                                      input logic commit, input logic shift);
        if (load_dvd) begin
            return OpLoadDividend;
        end
        if (load_dvsr) begin
            return OpLoadDivisor;
        end
        if (commit) begin
            return OpCommit;
        end
        if (shift) begin
            return OpShift;
        end
        return OpIdle;
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// One restoring-division step: shift the partial remainder left and trial-subtract the divisor.
module div_trial_sub
    import divider_datapath_pkg::*;
(
    input  logic [REM_W-1:0]  rem_cur,
    input  logic [DATA_W-1:0] dvsr,
    output logic [REM_W-1:0]  rem_next
);

    logic [DATA_W:0] diff;
    logic            unused_msb;

    // The shifted-out top bit is discarded by the iteration rule.
    assign unused_msb = rem_cur[REM_W-1];

    always_comb begin
        diff = {1'b0, rem_cur[REM_W-2:DATA_W-1]} - {1'b0, dvsr};
        if (!diff[DATA_W]) begin
            rem_next = {diff[DATA_W-1:0], rem_cur[DATA_W-2:0], 1'b1};
        end else begin
            rem_next = {rem_cur[REM_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider_datapath.sv
// Iterative unsigned 32/32 divider datapath driven by an external controller.
// Optional divide-by-zero flag output enabled by defining DIV_ZERO_DETECT_EN.
module divider_datapath
    import divider_datapath_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dividend_in,
    input  logic [DATA_W-1:0] divisor_in,
    input  logic              w_ctrl_reg1,
    input  logic              w_ctrl_reg2,
    input  logic              SLL_ctrl,
    input  logic              SRL_ctrl,
    input  logic              rdy,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              result_valid,
`ifdef DIV_ZERO_DETECT_EN
    output logic              div_zero,
`endif
    output logic              seq_err
);

    op_e               op;
    logic [REM_W-1:0]  rem_q, rem_d, rem_trial;
    logic [DATA_W-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0]  iter_cnt_q, iter_cnt_d;

    assign op = decode_op(w_ctrl_reg1, w_ctrl_reg2, SRL_ctrl && rdy, SLL_ctrl);

    div_trial_sub u_trial (
        .rem_cur  (rem_q),
        .dvsr     (dvsr_q),
        .rem_next (rem_trial)
    );

    always_comb begin
        rem_d      = rem_q;
        dvsr_d     = dvsr_q;
        iter_cnt_d = iter_cnt_q;
        unique case (op)
            OpLoadDividend: begin
                rem_d      = {{DATA_W{1'b0}}, dividend_in};
                iter_cnt_d = '0;
            end
            OpLoadDivisor: dvsr_d = divisor_in;
            OpShift: begin
                rem_d = rem_trial;
                // Saturate so a runaway controller cannot wrap back to a "valid" count.
                if (iter_cnt_q != {CNT_W{1'b1}}) begin
                    iter_cnt_d = iter_cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q      <= '0;
            dvsr_q     <= '0;
            iter_cnt_q <= '0;
        end else begin
            rem_q      <= rem_d;
            dvsr_q     <= dvsr_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient     <= '0;
            remainder    <= '0;
            result_valid <= 1'b0;
            seq_err      <= 1'b0;
        end else begin
            result_valid <= (op == OpCommit);
            if (op == OpCommit) begin
                quotient  <= rem_q[DATA_W-1:0];
                remainder <= rem_q[REM_W-1:DATA_W];
                if (iter_cnt_q != CNT_W'(ITER_N)) begin
                    seq_err <= 1'b1;
                end
            end else if (op == OpLoadDividend) begin
                seq_err <= 1'b0;
            end
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_zero <= 1'b0;
        end else if (op == OpCommit) begin
            div_zero <= (dvsr_q == '0);
        end else if (op == OpLoadDividend) begin
            div_zero <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_divider_datapath.sv
// Randomized and directed bench for divider_datapath with an arithmetic reference model.
module tb_divider_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dividend_in, divisor_in;
    logic        w_ctrl_reg1, w_ctrl_reg2, SLL_ctrl, SRL_ctrl, rdy;
    logic [31:0] quotient, remainder;
    logic        result_valid, seq_err;
`ifdef DIV_ZERO_DETECT_EN
    logic        div_zero;
`endif

    divider_datapath dut (
        .clk          (clk),
        .rst          (rst),
        .dividend_in  (dividend_in),
        .divisor_in   (divisor_in),
        .w_ctrl_reg1  (w_ctrl_reg1),
        .w_ctrl_reg2  (w_ctrl_reg2),
        .SLL_ctrl     (SLL_ctrl),
        .SRL_ctrl     (SRL_ctrl),
        .rdy          (rdy),
        .quotient     (quotient),
        .remainder    (remainder),
        .result_valid (result_valid),
`ifdef DIV_ZERO_DETECT_EN
        .div_zero     (div_zero),
`endif
        .seq_err      (seq_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit run      = 1'b0;

    // Reference model state: operands, iteration count and expected outputs.
    bit [31:0] m_dvd, m_dvsr, e_q, e_r;
    int        m_k;
    bit        e_valid, e_err, e_dz, e_known;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // After k steps (k<=32, divisor<=2^31) the top k dividend bits are divided,
    // the remaining dividend bits sit above the partial quotient.
    function automatic void predict(input bit [31:0] dvd, input bit [31:0] dvsr, input int k,
                                    output bit [31:0] q, output bit [31:0] r);
        bit [63:0] top, qk, rk, low;
        top = (k == 0) ? 64'd0 : ({32'd0, dvd} >> (32 - k));
        if (dvsr == 0) begin
            qk = (64'd1 << k) - 64'd1;
            rk = top;
        end else begin
            qk = top / {32'd0, dvsr};
            rk = top % {32'd0, dvsr};
        end
        low = {32'd0, dvd} << k;
        q = low[31:0] | qk[31:0];
        r = rk[31:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_dvd = 0; m_dvsr = 0; m_k = 0;
            e_q = 0; e_r = 0; e_valid = 0; e_err = 0; e_dz = 0; e_known = 1;
        end else begin
            e_valid = 0;
            if (w_ctrl_reg1) begin
                m_dvd = dividend_in; m_k = 0; e_err = 0; e_dz = 0;
            end else if (w_ctrl_reg2) begin
                m_dvsr = divisor_in;
            end else if (SRL_ctrl && rdy) begin
                if (m_k <= 32) begin
                    predict(m_dvd, m_dvsr, m_k, e_q, e_r);
                    e_known = 1;
                end else begin
                    e_known = 0;
                end
                e_valid = 1;
                if (m_k != 32) e_err = 1;
                e_dz = (m_dvsr == 0);
            end else if (SLL_ctrl) begin
                m_k = (m_k < 63) ? m_k + 1 : 63;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("result_valid", {31'd0, result_valid}, {31'd0, e_valid});
            chk("seq_err", {31'd0, seq_err}, {31'd0, e_err});
`ifdef DIV_ZERO_DETECT_EN
            chk("div_zero", {31'd0, div_zero}, {31'd0, e_dz});
`endif
            if (e_known) begin
                chk("quotient", quotient, e_q);
                chk("remainder", remainder, e_r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        w_ctrl_reg1 = 0; w_ctrl_reg2 = 0; SLL_ctrl = 0; SRL_ctrl = 0; rdy = 0;
    endtask

    task automatic load(input bit [31:0] dvd, input bit [31:0] dvsr);
        w_ctrl_reg1 = 1; dividend_in = dvd; tick(); clear_ctrl();
        w_ctrl_reg2 = 1; divisor_in = dvsr; tick(); clear_ctrl();
    endtask

    task automatic shifts(input int n);
        SLL_ctrl = 1;
        repeat (n) tick();
        clear_ctrl();
    endtask

    task automatic commit();
        SRL_ctrl = 1; rdy = 1; tick(); clear_ctrl();
    endtask

    task automatic divide(input bit [31:0] dvd, input bit [31:0] dvsr, input int n);
        load(dvd, dvsr);
        shifts(n);
        commit();
    endtask

    initial begin
        bit [31:0] dvd, dvsr;
        int        n;
        clear_ctrl();
        dividend_in = 0; divisor_in = 0;
        rst = 1;
        #1;
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_valid", {31'd0, result_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        run = 1;
        tick();

        // Directed cases with hand-computed results.
        divide(32'd100, 32'd7, 32);
        chk("q_100_7", quotient, 32'd14);
        chk("r_100_7", remainder, 32'd2);
        chk("v_100_7", {31'd0, result_valid}, 32'd1);
        chk("err_100_7", {31'd0, seq_err}, 32'd0);
        tick();
        chk("v_100_7_drop", {31'd0, result_valid}, 32'd0);

        divide(32'hFFFF_FFFF, 32'd1, 32);
        chk("q_max_1", quotient, 32'hFFFF_FFFF);
        chk("r_max_1", remainder, 32'd0);

        divide(32'd5, 32'd10, 32);
        chk("q_5_10", quotient, 32'd0);
        chk("r_5_10", remainder, 32'd5);

        divide(32'h1234, 32'd0, 32);
        chk("q_div0", quotient, 32'hFFFF_FFFF);
        chk("r_div0", remainder, 32'h1234);
`ifdef DIV_ZERO_DETECT_EN
        chk("dz_div0", {31'd0, div_zero}, 32'd1);
`endif

        // Back-to-back commits keep result_valid high.
        SRL_ctrl = 1; rdy = 1; tick(); tick(); clear_ctrl();
        chk("v_held", {31'd0, result_valid}, 32'd1);

        divide(32'd1000, 32'd3, 10);
        chk("err_short", {31'd0, seq_err}, 32'd1);
        w_ctrl_reg1 = 1; dividend_in = 32'd9; tick(); clear_ctrl();
        chk("err_cleared", {31'd0, seq_err}, 32'd0);

        // 96 shifts would wrap a non-saturating 6-bit count back to 32.
        divide(32'd77, 32'd5, 96);
        chk("err_saturate", {31'd0, seq_err}, 32'd1);

        // Asynchronous reset mid-operation.
        divide(32'd500, 32'd9, 32);
        load(32'd600, 32'd11);
        SLL_ctrl = 1; tick(); tick();
        #2 rst = 1;
        #1;
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_err", {31'd0, seq_err}, 32'd0);
        clear_ctrl();
        @(posedge clk);
        #1 rst = 0;
        repeat (3) tick();

        // Simultaneous load and shift: load wins, count restarts at zero.
        w_ctrl_reg2 = 1; divisor_in = 32'd6; tick(); clear_ctrl();
        w_ctrl_reg1 = 1; SLL_ctrl = 1; dividend_in = 32'd45; tick(); clear_ctrl();
        shifts(32);
        commit();
        chk("q_45_6", quotient, 32'd7);
        chk("r_45_6", remainder, 32'd3);
        chk("err_45_6", {31'd0, seq_err}, 32'd0);

        // Randomized transactions; lower-priority controls are jittered on load cycles.
        for (int t = 0; t < 60; t++) begin
            dvd = $urandom;
            case ($urandom_range(0, 5))
                0: dvsr = 32'd0;
                1: dvsr = 32'd1;
                2: dvsr = 32'h8000_0000;
                3: dvsr = $urandom_range(1, 255);
                default: dvsr = $urandom & 32'h7FFF_FFFF;
            endcase
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 33) : 32;
            for (int s = 0; s < 2; s++) begin
                if ((s == 0) == ($urandom_range(0, 1) == 0)) begin
                    w_ctrl_reg1 = 1; dividend_in = dvd;
                end else begin
                    w_ctrl_reg2 = 1; divisor_in = dvsr;
                end
                SLL_ctrl = 1'($urandom); SRL_ctrl = 1'($urandom); rdy = 1'($urandom);
                tick();
                clear_ctrl();
            end
            if (w_ctrl_reg1 == 0 && dividend_in != dvd) begin
                w_ctrl_reg1 = 1; dividend_in = dvd; tick(); clear_ctrl();
            end
            for (int i = 0; i < n; ) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 1) SRL_ctrl = 1; else rdy = 1;
                end else begin
                    SLL_ctrl = 1;
                    SRL_ctrl = 1'($urandom);
                    i++;
                end
                tick();
                clear_ctrl();
            end
            SRL_ctrl = 1; rdy = 1;
            repeat ($urandom_range(1, 2)) tick();
            clear_ctrl();
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        run = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
